odd_count_checker: RTL and testbench

Sequence checker sitting on the output bus of the 8-bit odd counter. It consumes the sampled count stream (1, 3, 5 … 255, 1 …) and locks onto the sequence. It flags every step that is not +2 modulo 2^WIDTH, counts errors and wraps, and latches a fault after repeated consecutive misses. It is the receiving end of the counter interface and is used both as an in-design monitor and as a self-checking bench component.

---
 rtl/odd_count_checker_if.sv | 10 +
 rtl/odd_count_checker.sv | 123 ++++++++++++
 tb/tb_odd_count_checker.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/odd_count_checker_if.sv
// rtl/odd_count_checker_if.sv - sampled count bus from the odd counter to its checker
interface odd_count_checker_if #(
    parameter int WIDTH = 8
);
    logic             cnt_valid;
    logic [WIDTH-1:0] cnt;

    modport master (output cnt_valid, output cnt);
    modport slave  (input  cnt_valid, input  cnt);
endinterface

// File: rtl/odd_count_checker.sv
// rtl/odd_count_checker.sv - locks onto the odd count stream, flags steps other than +2
module odd_count_checker #(
    parameter int WIDTH    = 8,
    parameter int MAX_MISS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    odd_count_checker_if.slave    bus,
    output logic                  locked_o,
    output logic                  fault_o,
    output logic                  err_o,
    output logic                  even_err_o,
    output logic [7:0]            err_count_o,
    output logic [7:0]            wrap_count_o
);
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP    = WIDTH'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [3:0]       miss_run_q, miss_run_d;
    logic             last_max_q, last_max_d;
    logic             err_q, err_d;
    logic             even_err_q, even_err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [7:0]       wrap_count_q, wrap_count_d;
    logic [3:0]       miss_inc;

    assign miss_inc = miss_run_q + 4'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= HUNT;
            expected_q   <= '0;
            miss_run_q   <= '0;
            last_max_q   <= 1'b0;
            err_q        <= 1'b0;
            even_err_q   <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            miss_run_q   <= miss_run_d;
            last_max_q   <= last_max_d;
            err_q        <= err_d;
            even_err_q   <= even_err_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        miss_run_d   = miss_run_q;
        last_max_d   = last_max_q;
        err_d        = 1'b0;
        even_err_d   = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;

        // clear wins over a same-cycle sample, which is simply dropped
        if (clear_i) begin
            state_d      = HUNT;
            miss_run_d   = '0;
            last_max_d   = 1'b0;
            err_count_d  = '0;
            wrap_count_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (bus.cnt_valid) begin
                        if (bus.cnt[0]) begin
                            expected_d = bus.cnt + STEP;
                            miss_run_d = '0;
                            last_max_d = (bus.cnt == CNT_MAX);
                            state_d    = LOCK;
                        end else begin
                            even_err_d = 1'b1;
                        end
                    end
                end
                LOCK: begin
                    if (bus.cnt_valid) begin
                        expected_d = bus.cnt + STEP;
                        if (bus.cnt == expected_q) begin
                            miss_run_d = '0;
                            if (last_max_q && bus.cnt == CNT_ONE && wrap_count_q != 8'hFF)
                                wrap_count_d = wrap_count_q + 8'd1;
                            last_max_d = (bus.cnt == CNT_MAX);
                        end else begin
                            err_d      = 1'b1;
                            even_err_d = ~bus.cnt[0];
                            if (err_count_q != 8'hFF)
                                err_count_d = err_count_q + 8'd1;
                            last_max_d = 1'b0;
                            miss_run_d = miss_inc;
                            if (miss_inc == 4'(MAX_MISS))
                                state_d = FAULT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign locked_o     = (state_q == LOCK);
    assign fault_o      = (state_q == FAULT);
    assign err_o        = err_q;
    assign even_err_o   = even_err_q;
    assign err_count_o  = err_count_q;
    assign wrap_count_o = wrap_count_q;
endmodule

// File: tb/tb_odd_count_checker.sv
// tb/tb_odd_count_checker.sv - directed bench for odd_count_checker
module tb_odd_count_checker;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       locked, fault, err, even_err;
    logic [7:0] err_count, wrap_count;
    int         total = 0;
    int         bad   = 0;

    odd_count_checker_if #(.WIDTH(8)) bus ();

    odd_count_checker #(.WIDTH(8), .MAX_MISS(3)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .bus          (bus),
        .locked_o     (locked),
        .fault_o      (fault),
        .err_o        (err),
        .even_err_o   (even_err),
        .err_count_o  (err_count),
        .wrap_count_o (wrap_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [7:0] c, input logic clr);
        @(negedge clk);
        bus.cnt_valid = v;
        bus.cnt       = c;
        clear         = clr;
        @(posedge clk);
        #1;
        bus.cnt_valid = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.cnt_valid = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({locked, fault, err, even_err, err_count, wrap_count} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs: got l=%b f=%b e=%b ee=%b ec=%0d wc=%0d want all 0",
                     locked, fault, err, even_err, err_count, wrap_count);
        end
    endtask

    task automatic test_clean_stream();
        int fails = 0;
        do_reset();
        for (int v = 1; v <= 255; v += 2) begin
            drive(1'b1, 8'(v), 1'b0);
            if ({err, even_err, locked} !== 3'b001) fails++;
        end
        drive(1'b1, 8'd1, 1'b0);
        if ({err, even_err, locked} !== 3'b001) fails++;
        drive(1'b1, 8'd3, 1'b0);
        if ({err, even_err, locked} !== 3'b001) fails++;
        total++;
        if (fails != 0) begin
            bad++;
            $display("FAIL clean_flags: %0d cycles with bad err/even_err/locked, want 0", fails);
        end
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL clean_err_count: got %0d want 0", err_count);
        end
        total++;
        if (wrap_count !== 8'd1) begin
            bad++;
            $display("FAIL clean_wrap_count: got %0d want 1", wrap_count);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        drive(1'b1, 8'd7, 1'b0);
        drive(1'b1, 8'd9, 1'b0);
        drive(1'b1, 8'd15, 1'b0);
        total++;
        if ({err, even_err, locked, err_count} !== {3'b101, 8'd1}) begin
            bad++;
            $display("FAIL single_err_pulse: got e=%b ee=%b l=%b ec=%0d want 1 0 1 1",
                     err, even_err, locked, err_count);
        end
        drive(1'b1, 8'd17, 1'b0);
        drive(1'b1, 8'd19, 1'b0);
        total++;
        if ({err, locked, err_count} !== {2'b01, 8'd1}) begin
            bad++;
            $display("FAIL single_err_resync: got e=%b l=%b ec=%0d want 0 1 1", err, locked, err_count);
        end
    endtask

    task automatic test_even_in_lock();
        do_reset();
        drive(1'b1, 8'd5, 1'b0);
        drive(1'b1, 8'd7, 1'b0);
        drive(1'b1, 8'd8, 1'b0);
        total++;
        if ({err, even_err, err_count} !== {2'b11, 8'd1}) begin
            bad++;
            $display("FAIL even_in_lock: got e=%b ee=%b ec=%0d want 1 1 1", err, even_err, err_count);
        end
        drive(1'b1, 8'd20, 1'b0);
        total++;
        if ({locked, fault} !== 2'b10) begin
            bad++;
            $display("FAIL even_miss2: got l=%b f=%b want 1 0", locked, fault);
        end
        drive(1'b1, 8'd30, 1'b0);
        total++;
        if ({locked, fault, err_count} !== {2'b01, 8'd3}) begin
            bad++;
            $display("FAIL even_miss3_fault: got l=%b f=%b ec=%0d want 0 1 3", locked, fault, err_count);
        end
    endtask

    task automatic test_fault();
        do_reset();
        drive(1'b1, 8'd1, 1'b0);
        drive(1'b1, 8'd3, 1'b0);
        drive(1'b1, 8'd11, 1'b0);
        drive(1'b1, 8'd21, 1'b0);
        total++;
        if ({locked, fault, err} !== 3'b101) begin
            bad++;
            $display("FAIL fault_early: got l=%b f=%b e=%b want 1 0 1", locked, fault, err);
        end
        drive(1'b1, 8'd31, 1'b0);
        total++;
        if ({locked, fault, err, err_count} !== {3'b011, 8'd3}) begin
            bad++;
            $display("FAIL fault_enter: got l=%b f=%b e=%b ec=%0d want 0 1 1 3", locked, fault, err, err_count);
        end
        drive(1'b1, 8'd33, 1'b0);
        drive(1'b1, 8'd35, 1'b0);
        total++;
        if ({fault, err, even_err, err_count, wrap_count} !== {3'b100, 8'd3, 8'd0}) begin
            bad++;
            $display("FAIL fault_frozen: got f=%b e=%b ee=%b ec=%0d wc=%0d want 1 0 0 3 0",
                     fault, err, even_err, err_count, wrap_count);
        end
        drive(1'b0, 8'd0, 1'b1);
        total++;
        if ({locked, fault, err_count} !== {2'b00, 8'd0}) begin
            bad++;
            $display("FAIL fault_clear: got l=%b f=%b ec=%0d want 0 0 0", locked, fault, err_count);
        end
        drive(1'b1, 8'd41, 1'b0);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL fault_relock: got l=%b want 1", locked);
        end
    endtask

    task automatic test_hunt_even();
        do_reset();
        drive(1'b1, 8'd4, 1'b0);
        total++;
        if ({even_err, err, locked} !== 3'b100) begin
            bad++;
            $display("FAIL hunt_even_4: got ee=%b e=%b l=%b want 1 0 0", even_err, err, locked);
        end
        drive(1'b1, 8'd6, 1'b0);
        total++;
        if ({even_err, err, locked} !== 3'b100) begin
            bad++;
            $display("FAIL hunt_even_6: got ee=%b e=%b l=%b want 1 0 0", even_err, err, locked);
        end
        drive(1'b1, 8'd9, 1'b0);
        total++;
        if ({even_err, err, locked} !== 3'b001) begin
            bad++;
            $display("FAIL hunt_lock_9: got ee=%b e=%b l=%b want 0 0 1", even_err, err, locked);
        end
        drive(1'b1, 8'd11, 1'b0);
        total++;
        if ({err, locked, err_count} !== {2'b01, 8'd0}) begin
            bad++;
            $display("FAIL hunt_follow_11: got e=%b l=%b ec=%0d want 0 1 0", err, locked, err_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 8'd1, 1'b0);
        drive(1'b1, 8'd3, 1'b0);
        drive(1'b1, 8'd9, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({locked, fault, err, even_err, err_count, wrap_count} !== 20'h0) begin
            bad++;
            $display("FAIL async_reset: got l=%b f=%b e=%b ee=%b ec=%0d wc=%0d want all 0",
                     locked, fault, err, even_err, err_count, wrap_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clear_with_valid();
        do_reset();
        drive(1'b1, 8'd11, 1'b0);
        drive(1'b1, 8'd21, 1'b0);
        total++;
        if ({locked, err_count} !== {1'b1, 8'd1}) begin
            bad++;
            $display("FAIL clear_pre: got l=%b ec=%0d want 1 1", locked, err_count);
        end
        drive(1'b1, 8'd13, 1'b1);
        total++;
        if ({locked, fault, err, even_err, err_count} !== {4'b0000, 8'd0}) begin
            bad++;
            $display("FAIL clear_with_valid: got l=%b f=%b e=%b ee=%b ec=%0d want 0 0 0 0 0",
                     locked, fault, err, even_err, err_count);
        end
    endtask

    task automatic test_saturate();
        logic [7:0] cur;
        do_reset();
        cur = 8'd1;
        drive(1'b1, cur, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cur = cur + 8'd4;
            drive(1'b1, cur, 1'b0);
            cur = cur + 8'd2;
            drive(1'b1, cur, 1'b0);
        end
        total++;
        if ({locked, fault, err_count} !== {2'b10, 8'd255}) begin
            bad++;
            $display("FAIL err_count_saturate: got l=%b f=%b ec=%0d want 1 0 255", locked, fault, err_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        bus.cnt_valid = 1'b0;
        bus.cnt = 8'd0;
        test_reset();
        test_clean_stream();
        test_single_error();
        test_even_in_lock();
        test_fault();
        test_hunt_even();
        test_async_reset();
        test_clear_with_valid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
